pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush controller for the 5-stage pipeline. Merges stall requests from
//  IF, ID, EX and MEM into the 6-bit stall vector (bit0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM,
//  4 MEM/WB, 5 WB) consumed by PC and every pipeline register. Sequences exception
//  flushes, deferring them while a MEM bus access is stalled, and drives the redirect PC.
//  Hosts a stall watchdog for hung bus or divider requests.
// PARAMETERS
//  EXC_VECTOR  32'h0000_0020  redirect target for every exception except ERET
//  ERET_TYPE   32'h0000_000e  excepttype_i code meaning ERET; redirect is cp0_epc_i
//  WDOG_LIMIT  1023           consecutive stalled cycles that raise stall_timeout
//  WDOG_W      10             watchdog counter width; WDOG_LIMIT must fit in it
// PORTS
//  clk               in   1   clock, all state updates on rising edge
//  rst               in   1   asynchronous, active-low reset (0 = reset)
//  stallreq_from_if  in   1   instruction fetch not ready
//  stallreq_from_id  in   1   ID hazard (load-use)
//  stallreq_from_ex  in   1   EX multi-cycle op busy (div, madd)
//  stallreq_from_mem in   1   data bus access not complete
//  excepttype_i      in   32  exception type from MEM stage, 0 = none
//  cp0_epc_i         in   32  current EPC
//  stall             out  6   stall vector, bit=1 holds that stage
//  flush             out  1   1-cycle pulse, clears all pipeline registers
//  new_pc            out  32  redirect PC, valid only when flush=1, else 0
//  stall_timeout     out  1   registered 1-cycle pulse on watchdog expiry
// BEHAVIOUR
//  States: RUN, PEND. stall, flush, new_pc are combinational from inputs + state, so
//  stages see them in the same cycle (0 latency). stall_timeout is registered.
//  Reset (rst=0, async): state=RUN, latched type/EPC=0, wdog count=0, stall_timeout=0;
//  combinational outputs forced stall=0, flush=0, new_pc=0 while rst=0.
//  RUN, priority highest first:
//   - excepttype_i!=0 && !stallreq_from_mem: flush=1, stall=0, new_pc = cp0_epc_i if
//     excepttype_i==ERET_TYPE else EXC_VECTOR; stay RUN.
//   - excepttype_i!=0 && stallreq_from_mem: latch excepttype_i, cp0_epc_i; stall=6'b011111,
//     flush=0; -> PEND.
//   - stallreq_from_mem: stall=6'b011111.  - stallreq_from_ex: stall=6'b001111.
//   - stallreq_from_id: stall=6'b000111.   - stallreq_from_if: stall=6'b000011.
//   - none: stall=6'b000000.
//  PEND: all other requests and excepttype_i ignored.
//   - stallreq_from_mem=1: stall=6'b011111, remain PEND.
//   - stallreq_from_mem=0: flush=1, stall=0, new_pc from LATCHED type/EPC; -> RUN.
//  Watchdog: count clears when stall==0 or flush=1; else increments, saturating at
//  WDOG_LIMIT. stall_timeout=1 for exactly the cycle after count first reaches
//  WDOG_LIMIT; no repeat until count clears. Watchdog never alters stall/flush.
//  Flush always overrides stall; flush and any stall bit are never 1 together.
//  Back-to-back exceptions in consecutive RUN cycles give consecutive flush pulses.
//  Reset asserted in PEND discards the pending exception (no flush after release).
// TESTING
//  1 id=1, ex=1 same cycle -> stall=6'b001111; drop ex -> 6'b000111; drop id -> 0.
//  2 excepttype_i=32'h8, mem=0 -> same cycle flush=1, new_pc=32'h20, stall=0; next
//    cycle flush=0, new_pc=0.
//  3 excepttype_i=32'he, cp0_epc_i=32'h1234 -> flush=1, new_pc=32'h1234.
//  4 mem=1 3 cycles with excepttype_i=32'h8 then cp0_epc_i/type changed -> stall=6'b011111
//    3 cycles, no flush; mem=0 -> flush=1 once, new_pc=32'h20 (latched type).
//  5 WDOG_LIMIT=4, ex held 6 cycles -> stall_timeout=1 exactly once, cycle after 4th
//    stalled cycle; ex=0 one cycle then ex=1 4 cycles -> pulses again.
//  6 enter PEND, assert rst=0 mid-wait -> outputs 0 immediately; release with mem=0,
//    excepttype_i=0 -> no flush, state RUN.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Stall/flush control bundle between the pipeline stages and pipeline_ctrl.
// Stages drive requests and the exception; the controller drives stall/flush/redirect.
interface pipeline_ctrl_if;
    logic        stallreq_from_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;

    modport master (
        output stallreq_from_if, stallreq_from_id,
        output stallreq_from_ex, stallreq_from_mem,
        output excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc, stall_timeout
    );

    modport slave (
        input  stallreq_from_if, stallreq_from_id,
        input  stallreq_from_ex, stallreq_from_mem,
        input  excepttype_i, cp0_epc_i,
        output stall, flush, new_pc, stall_timeout
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: merges stage stall requests, sequences
// exception flushes (deferred behind a stalled MEM access) and a stall watchdog.
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter logic [31:0] ERET_TYPE  = 32'h0000_000e,
    parameter int          WDOG_LIMIT = 1023,
    parameter int          WDOG_W     = 10
) (
    input logic           clk,
    input logic           rst,
    pipeline_ctrl_if.slave bus
);

    typedef enum logic {RUN, PEND} state_t;

    localparam logic [WDOG_W-1:0] LIM = WDOG_W'(WDOG_LIMIT);

    state_t            state_q, state_d;
    logic [31:0]       type_q, type_d;
    logic [31:0]       epc_q, epc_d;
    logic [5:0]        stall_c;
    logic              flush_c;
    logic [31:0]       pc_c;
    logic [WDOG_W-1:0] cnt_q;
    logic              to_q;
    logic              stalled;

    function automatic logic [31:0] redirect(input logic [31:0] t,
                                             input logic [31:0] e);
        return (t == ERET_TYPE) ? e : EXC_VECTOR;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            type_q  <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            epc_q   <= epc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        epc_d   = epc_q;
        stall_c = 6'b000000;
        flush_c = 1'b0;
        pc_c    = '0;
        if (rst) begin
            unique case (state_q)
                RUN: begin
                    if (bus.excepttype_i != '0 && !bus.stallreq_from_mem) begin
                        flush_c = 1'b1;
                        pc_c    = redirect(bus.excepttype_i, bus.cp0_epc_i);
                    end else if (bus.excepttype_i != '0) begin
                        type_d  = bus.excepttype_i;
                        epc_d   = bus.cp0_epc_i;
                        stall_c = 6'b011111;
                        state_d = PEND;
                    end else if (bus.stallreq_from_mem) begin
                        stall_c = 6'b011111;
                    end else if (bus.stallreq_from_ex) begin
                        stall_c = 6'b001111;
                    end else if (bus.stallreq_from_id) begin
                        stall_c = 6'b000111;
                    end else if (bus.stallreq_from_if) begin
                        stall_c = 6'b000011;
                    end
                end
                PEND: begin
                    // Exception waits for the bus access; new inputs are ignored.
                    if (bus.stallreq_from_mem) begin
                        stall_c = 6'b011111;
                    end else begin
                        flush_c = 1'b1;
                        pc_c    = redirect(type_q, epc_q);
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign stalled = (stall_c != 6'b000000) && !flush_c;

    // Saturating count; the pulse fires only on the step into LIM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            to_q <= 1'b0;
            if (!stalled) begin
                cnt_q <= '0;
            end else if (cnt_q != LIM) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == LIM - 1'b1) to_q <= 1'b1;
            end
        end
    end

    assign bus.stall         = stall_c;
    assign bus.flush         = flush_c;
    assign bus.new_pc        = pc_c;
    assign bus.stall_timeout = to_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares the combinational/registered outputs.
module tb_pipeline_ctrl;

    typedef struct {
        int          id;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        to;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    exp_t sb[$];

    pipeline_ctrl_if ifc ();

    pipeline_ctrl #(
        .WDOG_LIMIT(4),
        .WDOG_W    (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int id, input logic r,
                        input logic fi, input logic fd,
                        input logic fe, input logic fm,
                        input logic [31:0] t, input logic [31:0] epc,
                        input logic [5:0] es, input logic ef,
                        input logic [31:0] ep, input logic et);
        exp_t e;
        @(posedge clk);
        #1;
        rst                   = r;
        ifc.stallreq_from_if  = fi;
        ifc.stallreq_from_id  = fd;
        ifc.stallreq_from_ex  = fe;
        ifc.stallreq_from_mem = fm;
        ifc.excepttype_i      = t;
        ifc.cp0_epc_i         = epc;
        e.id = id; e.stall = es; e.flush = ef; e.pc = ep; e.to = et;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_chk = n_chk + 1;
            if (ifc.stall === e.stall && ifc.flush === e.flush &&
                ifc.new_pc === e.pc && ifc.stall_timeout === e.to) begin
                n_pass = n_pass + 1;
            end else begin
                $display("FAIL vec%0d: got stall=%b flush=%b pc=%h to=%b, want stall=%b flush=%b pc=%h to=%b",
                         e.id, ifc.stall, ifc.flush, ifc.new_pc, ifc.stall_timeout,
                         e.stall, e.flush, e.pc, e.to);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst                   = 1'b0;
        ifc.stallreq_from_if  = 1'b0;
        ifc.stallreq_from_id  = 1'b0;
        ifc.stallreq_from_ex  = 1'b0;
        ifc.stallreq_from_mem = 1'b0;
        ifc.excepttype_i      = '0;
        ifc.cp0_epc_i         = '0;
        //     id  r  if id ex mm type    epc            stall    fl pc          to
        step(0,  0, 0, 1, 0, 0, 32'h0, 32'h0,        6'b000000, 0, 32'h0,     0);
        step(1,  1, 0, 1, 1, 0, 32'h0, 32'h0,        6'b001111, 0, 32'h0,     0);
        step(2,  1, 0, 1, 0, 0, 32'h0, 32'h0,        6'b000111, 0, 32'h0,     0);
        step(3,  1, 0, 0, 0, 0, 32'h0, 32'h0,        6'b000000, 0, 32'h0,     0);
        step(4,  1, 0, 0, 0, 0, 32'h8, 32'h0,        6'b000000, 1, 32'h20,    0);
        step(5,  1, 0, 0, 0, 0, 32'h0, 32'h0,        6'b000000, 0, 32'h0,     0);
        step(6,  1, 0, 0, 0, 0, 32'he, 32'h1234,     6'b000000, 1, 32'h1234,  0);
        step(7,  1, 0, 0, 0, 0, 32'h8, 32'h1234,     6'b000000, 1, 32'h20,    0);
        step(8,  1, 0, 0, 0, 0, 32'h0, 32'h0,        6'b000000, 0, 32'h0,     0);
        step(9,  1, 0, 0, 0, 1, 32'h8, 32'h0,        6'b011111, 0, 32'h0,     0);
        step(10, 1, 0, 0, 0, 1, 32'he, 32'h5555,     6'b011111, 0, 32'h0,     0);
        step(11, 1, 0, 0, 1, 1, 32'he, 32'h5555,     6'b011111, 0, 32'h0,     0);
        step(12, 1, 0, 0, 0, 0, 32'he, 32'h5555,     6'b000000, 1, 32'h20,    0);
        step(13, 1, 0, 0, 0, 0, 32'h0, 32'h0,        6'b000000, 0, 32'h0,     0);
        step(14, 1, 0, 0, 0, 1, 32'he, 32'habcd,     6'b011111, 0, 32'h0,     0);
        step(15, 1, 0, 0, 0, 1, 32'h0, 32'h0,        6'b011111, 0, 32'h0,     0);
        step(16, 1, 0, 0, 0, 0, 32'h0, 32'h0,        6'b000000, 1, 32'habcd,  0);
        step(17, 1, 0, 0, 1, 0, 32'h0, 32'h0,        6'b001111, 0, 32'h0,     0);
        step(18, 1, 0, 0, 1, 0, 32'h0, 32'h0,        6'b001111, 0, 32'h0,     0);
        step(19, 1, 0, 0, 1, 0, 32'h0, 32'h0,        6'b001111, 0, 32'h0,     0);
        step(20, 1, 0, 0, 1, 0, 32'h0, 32'h0,        6'b001111, 0, 32'h0,     0);
        step(21, 1, 0, 0, 1, 0, 32'h0, 32'h0,        6'b001111, 0, 32'h0,     1);
        step(22, 1, 0, 0, 1, 0, 32'h0, 32'h0,        6'b001111, 0, 32'h0,     0);
        step(23, 1, 0, 0, 0, 0, 32'h0, 32'h0,        6'b000000, 0, 32'h0,     0);
        step(24, 1, 0, 0, 1, 0, 32'h0, 32'h0,        6'b001111, 0, 32'h0,     0);
        step(25, 1, 0, 0, 1, 0, 32'h0, 32'h0,        6'b001111, 0, 32'h0,     0);
        step(26, 1, 0, 0, 1, 0, 32'h0, 32'h0,        6'b001111, 0, 32'h0,     0);
        step(27, 1, 0, 0, 1, 0, 32'h0, 32'h0,        6'b001111, 0, 32'h0,     0);
        step(28, 1, 0, 0, 0, 0, 32'h0, 32'h0,        6'b000000, 0, 32'h0,     1);
        step(29, 1, 1, 0, 0, 0, 32'h0, 32'h0,        6'b000011, 0, 32'h0,     0);
        step(30, 1, 1, 0, 0, 1, 32'h0, 32'h0,        6'b011111, 0, 32'h0,     0);
        step(31, 1, 0, 0, 0, 0, 32'h0, 32'h0,        6'b000000, 0, 32'h0,     0);
        step(32, 1, 0, 0, 0, 1, 32'h8, 32'h0,        6'b011111, 0, 32'h0,     0);
        step(33, 0, 0, 0, 0, 1, 32'h8, 32'h0,        6'b000000, 0, 32'h0,     0);
        step(34, 1, 0, 0, 0, 0, 32'h0, 32'h0,        6'b000000, 0, 32'h0,     0);
        step(35, 1, 0, 0, 0, 1, 32'h0, 32'h0,        6'b011111, 0, 32'h0,     0);
        step(36, 1, 0, 0, 0, 0, 32'h0, 32'h0,        6'b000000, 0, 32'h0,     0);
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_chk = n_chk + 1;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
